axi_stream_crc_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one axi_stream_sideband_crc instance between NUM_SRC AXI-Stream sources. A grant is locked from the first beat of a packet until its tlast handshake. The selected stream passes through one registered output stage, tagged with the source index in o_m_tid. Per-packet beat-count status is reported when each packet completes at the output.

---
 rtl/axi_stream_crc_arbiter_pkg.sv | 19 +
 rtl/axi_stream_crc_arbiter_rr_arbiter.sv | 30 +++
 rtl/axi_stream_crc_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_stream_crc_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_crc_arbiter_pkg.sv
// Shared constants, FSM state type and slice helper for the AXI-Stream CRC arbiter.
package axi_stream_crc_pkg;

    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_KEEP_BYTES = DEF_DATA_WIDTH / 8;
    localparam int DEF_BEAT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    // Low bit of source idx inside a packed per-source bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/axi_stream_crc_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching cyclically from ptr+1.
module rr_arbiter
    import axi_stream_crc_pkg::*;
#(
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] gnt_idx,
    output logic                gnt_vld
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_stream_crc_arbiter.sv
// Packet-locked round-robin mux of NUM_SRC AXI-Stream sources into one registered
// output stage feeding the CRC block, with per-packet beat-count status.
module axi_stream_crc_arbiter
    import axi_stream_crc_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_BYTES = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = $clog2(NUM_SRC),
    parameter int BEAT_W     = DEF_BEAT_W
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_SRC-1:0]            i_s_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_s_tdata,
    input  logic [NUM_SRC*KEEP_BYTES-1:0] i_s_tkeep,
    input  logic [NUM_SRC-1:0]            i_s_tlast,
    output logic [NUM_SRC-1:0]            o_s_tready,
    output logic                          o_m_tvalid,
    output logic [DATA_WIDTH-1:0]         o_m_tdata,
    output logic [KEEP_BYTES-1:0]         o_m_tkeep,
    output logic                          o_m_tlast,
    output logic [ID_WIDTH-1:0]           o_m_tid,
    input  logic                          i_m_tready,
    output logic                          o_busy,
    output logic                          o_pkt_done,
    output logic [BEAT_W-1:0]             o_pkt_beats
);

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_BYTES-1:0]   m_tkeep_q, m_tkeep_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [ID_WIDTH-1:0]     m_tid_q, m_tid_d;
    logic [BEAT_W-1:0]       cnt_q, cnt_d;
    logic                    pkt_done_q, pkt_done_d;
    logic [BEAT_W-1:0]       pkt_beats_q, pkt_beats_d;

    logic [NUM_SRC-1:0]      s_tready;
    logic [ID_WIDTH-1:0]     arb_idx;
    logic                    arb_vld;
    logic                    in_hs;
    logic                    out_hs;
    logic [BEAT_W-1:0]       cnt_inc;

    rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req     (i_s_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        m_tkeep_d   = m_tkeep_q;
        m_tlast_d   = m_tlast_q;
        m_tid_d     = m_tid_q;
        cnt_d       = cnt_q;
        pkt_done_d  = 1'b0;
        pkt_beats_d = pkt_beats_q;
        s_tready    = '0;
        in_hs       = 1'b0;
        out_hs      = m_tvalid_q && i_m_tready;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + BEAT_W'(1);

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                // Ready only when the output register is empty or draining this cycle.
                s_tready[grant_q] = !m_tvalid_q || i_m_tready;
                in_hs = i_s_tvalid[grant_q] && s_tready[grant_q];
                if (in_hs && i_s_tlast[grant_q]) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_hs) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = i_s_tdata[slice_lo(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH];
            m_tkeep_d  = i_s_tkeep[slice_lo(int'(grant_q), KEEP_BYTES) +: KEEP_BYTES];
            m_tlast_d  = i_s_tlast[grant_q];
            m_tid_d    = grant_q;
        end else if (out_hs) begin
            m_tvalid_d = 1'b0;
        end

        if (out_hs) begin
            if (m_tlast_q) begin
                pkt_beats_d = cnt_inc;
                pkt_done_d  = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= ID_WIDTH'(NUM_SRC - 1);
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tid_q     <= '0;
            cnt_q       <= '0;
            pkt_done_q  <= 1'b0;
            pkt_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tlast_q   <= m_tlast_d;
            m_tid_q     <= m_tid_d;
            cnt_q       <= cnt_d;
            pkt_done_q  <= pkt_done_d;
            pkt_beats_q <= pkt_beats_d;
        end
    end

    assign o_s_tready  = s_tready;
    assign o_m_tvalid  = m_tvalid_q;
    assign o_m_tdata   = m_tdata_q;
    assign o_m_tkeep   = m_tkeep_q;
    assign o_m_tlast   = m_tlast_q;
    assign o_m_tid     = m_tid_q;
    assign o_busy      = (state_q == PASS);
    assign o_pkt_done  = pkt_done_q;
    assign o_pkt_beats = pkt_beats_q;

endmodule

// File: tb/tb_axi_stream_crc_arbiter.sv
// Scoreboard bench: per-source beat queues drive the DUT, expected output beats and
// packet lengths are queued at issue time and checked by an independent monitor.
module tb_axi_stream_crc_arbiter;

    localparam int NS = 4;
    localparam int DW = 128;
    localparam int KB = DW / 8;
    localparam int IW = $clog2(NS);
    localparam int BW = 16;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NS-1:0]     s_tvalid;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS*KB-1:0]  s_tkeep;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     o_s_tready;
    logic              o_m_tvalid;
    logic [DW-1:0]     o_m_tdata;
    logic [KB-1:0]     o_m_tkeep;
    logic              o_m_tlast;
    logic [IW-1:0]     o_m_tid;
    logic              i_m_tready;
    logic              o_busy;
    logic              o_pkt_done;
    logic [BW-1:0]     o_pkt_beats;

    always #5 clk = ~clk;

    axi_stream_crc_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .KEEP_BYTES (KB),
        .ID_WIDTH   (IW),
        .BEAT_W     (BW)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_s_tvalid  (s_tvalid),
        .i_s_tdata   (s_tdata),
        .i_s_tkeep   (s_tkeep),
        .i_s_tlast   (s_tlast),
        .o_s_tready  (o_s_tready),
        .o_m_tvalid  (o_m_tvalid),
        .o_m_tdata   (o_m_tdata),
        .o_m_tkeep   (o_m_tkeep),
        .o_m_tlast   (o_m_tlast),
        .o_m_tid     (o_m_tid),
        .i_m_tready  (i_m_tready),
        .o_busy      (o_busy),
        .o_pkt_done  (o_pkt_done),
        .o_pkt_beats (o_pkt_beats)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
    } exp_t;

    beat_t     srcq[NS][$];
    exp_t      expq[$];
    int        beatsq[$];
    logic      rdyq[$];
    bit        loaded[NS];
    int        waitc[NS];
    logic [NS-1:0] hs;
    bit        sb_en = 1'b1;
    int        vec_cnt = 0;
    int        err_cnt = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Beat data pattern: {src, beat, BEEF} repeated across the 128-bit word.
    task automatic send_pkt(input int src, input int n, input int gap_at, input int gap_len,
                            input logic [KB-1:0] keep);
        beat_t bt;
        exp_t  e;
        for (int b = 0; b < n; b++) begin
            bt.data = {4{8'(src), 8'(b), 16'hBEEF}};
            bt.keep = keep;
            bt.last = (b == n - 1);
            bt.gap  = (b == gap_at) ? gap_len : 0;
            srcq[src].push_back(bt);
            e.tid  = IW'(src);
            e.data = bt.data;
            e.keep = keep;
            e.last = bt.last;
            expq.push_back(e);
        end
        beatsq.push_back(n);
    endtask

    function automatic bit sources_busy();
        bit r = 1'b0;
        for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) r = 1'b1;
        return r;
    endfunction

    task automatic drain();
        int t = 0;
        while ((expq.size() != 0 || beatsq.size() != 0 || sources_busy()) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", expq.size());
            expq.delete();
            beatsq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_tready"}, DW'(o_s_tready), '0);
        chk({nm, "_tvalid"}, DW'(o_m_tvalid), '0);
        chk({nm, "_tdata"},  o_m_tdata, '0);
        chk({nm, "_tkeep"},  DW'(o_m_tkeep), '0);
        chk({nm, "_tlast"},  DW'(o_m_tlast), '0);
        chk({nm, "_tid"},    DW'(o_m_tid), '0);
        chk({nm, "_busy"},   DW'(o_busy), '0);
        chk({nm, "_done"},   DW'(o_pkt_done), '0);
        chk({nm, "_beats"},  DW'(o_pkt_beats), '0);
    endtask

    // Source / sink driver: presents queue heads on the falling edge, records handshakes just before rise.
    initial begin
        s_tvalid   = '0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = '0;
        i_m_tready = 1'b1;
        hs         = '0;
        for (int s = 0; s < NS; s++) begin
            loaded[s] = 1'b0;
            waitc[s]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                if (hs[s] && srcq[s].size() != 0) begin
                    srcq[s].delete(0);
                    loaded[s] = 1'b0;
                end
                s_tvalid[s] = 1'b0;
                if (srcq[s].size() != 0) begin
                    if (!loaded[s]) begin
                        waitc[s]  = srcq[s][0].gap;
                        loaded[s] = 1'b1;
                    end
                    if (waitc[s] > 0) begin
                        waitc[s]--;
                    end else begin
                        s_tvalid[s]          = 1'b1;
                        s_tdata[s*DW +: DW]  = srcq[s][0].data;
                        s_tkeep[s*KB +: KB]  = srcq[s][0].keep;
                        s_tlast[s]           = srcq[s][0].last;
                    end
                end
            end
            i_m_tready = (rdyq.size() != 0) ? rdyq.pop_front() : 1'b1;
            #4;
            hs = s_tvalid & o_s_tready;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and on every packet-done pulse.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        exp_t          e;
        int            nb;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!arst_n) begin
                prev_stall = 1'b0;
            end else begin
                if ($countones(o_s_tready) > 1) chk("tready_onehot", DW'(o_s_tready), '0);
                if (prev_stall) begin
                    chk("stall_data", o_m_tdata, prev_data);
                    chk("stall_valid", DW'(o_m_tvalid), DW'(1));
                end
                if (sb_en && o_m_tvalid && i_m_tready) begin
                    if (expq.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_beat: got tid %0d data %0h expected none", o_m_tid, o_m_tdata);
                    end else begin
                        e = expq.pop_front();
                        chk("beat_tid",  DW'(o_m_tid), DW'(e.tid));
                        chk("beat_data", o_m_tdata, e.data);
                        chk("beat_keep", DW'(o_m_tkeep), DW'(e.keep));
                        chk("beat_last", DW'(o_m_tlast), DW'(e.last));
                    end
                end
                if (sb_en && o_pkt_done) begin
                    if (beatsq.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_done: got beats %0d expected none", o_pkt_beats);
                    end else begin
                        nb = beatsq.pop_front();
                        chk("pkt_beats", DW'(o_pkt_beats), DW'(nb));
                    end
                end
                prev_stall = o_m_tvalid && !i_m_tready;
                prev_data  = o_m_tdata;
            end
        end
    end

    task automatic do_reset();
        arst_n = 1'b0;
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            loaded[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        int t;
        arst_n = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        do_reset();

        // 1: lone 4-beat packet from source 0, one cycle of arbitration latency.
        @(posedge clk);
        send_pkt(0, 4, -1, 0, '1);
        @(negedge clk); #3;
        chk("t1_arb_latency", DW'(o_s_tready), '0);
        @(negedge clk); #3;
        chk("t1_grant0", DW'(o_s_tready), DW'(4'b0001));
        chk("t1_busy", DW'(o_busy), DW'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            chk("t1_back2back_valid", DW'(o_m_tvalid), DW'(1));
        end
        @(negedge clk); #3;
        chk("t1_valid_fall", DW'(o_m_tvalid), '0);
        chk("t1_done", DW'(o_pkt_done), DW'(1));
        chk("t1_beats", DW'(o_pkt_beats), DW'(4));
        chk("t1_busy_fall", DW'(o_busy), '0);
        drain();
        chk("t1_beats_held", DW'(o_pkt_beats), DW'(4));

        // 2: sources 0,1,2 together go in order; afterwards 3 beats 0 since rr_ptr=2.
        do_reset();
        @(posedge clk);
        send_pkt(0, 2, -1, 0, '1);
        send_pkt(1, 2, -1, 0, '1);
        send_pkt(2, 2, -1, 0, '1);
        drain();
        @(posedge clk);
        send_pkt(3, 2, -1, 0, '1);
        send_pkt(0, 2, -1, 0, '1);
        drain();

        // 3: downstream backpressure on a 3-beat packet.
        @(posedge clk);
        send_pkt(1, 3, -1, 0, '1);
        rdyq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        drain();
        chk("t3_beats", DW'(o_pkt_beats), DW'(3));

        // 4: granted source 2 idles 3 cycles mid-packet; source 1 must wait.
        @(posedge clk);
        send_pkt(2, 3, 1, 3, '1);
        send_pkt(1, 2, -1, 0, '1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #3;
            chk("t4_src1_blocked", DW'(o_s_tready[1]), '0);
        end
        drain();

        // 5: single-beat packet with partial keep.
        @(posedge clk);
        send_pkt(3, 1, -1, 0, 16'h0003);
        drain();
        chk("t5_beats", DW'(o_pkt_beats), DW'(1));

        // 6: reset while an output beat is valid, then source 0 wins first again.
        sb_en = 1'b0;
        @(posedge clk);
        send_pkt(2, 4, -1, 0, '1);
        expq.delete();
        beatsq.delete();
        t = 0;
        do begin
            @(negedge clk); #2;
            t++;
        end while (!o_m_tvalid && t < 20);
        chk("t6_valid_before_reset", DW'(o_m_tvalid), DW'(1));
        arst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            loaded[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        sb_en  = 1'b1;
        @(posedge clk);
        send_pkt(0, 2, -1, 0, '1);
        send_pkt(1, 2, -1, 0, '1);
        send_pkt(3, 1, -1, 0, '1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
